// File: rtl/axil_write_router.sv
// axil_write_router
// Write-channel routing stage of the AXI-Lite interconnect. It accepts one
// master write (AW, W, B) at a time, steers it to the slave picked by the
// address decoder and returns that slave's response. On a decode miss it
// absorbs the W beat itself and answers with DECERR.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   m_aw*/m_w*/m_b*                master-side write channels
//   dec_addr -> / dec_sel, dec_hit <-   address decoder lookup (combinational)
//   s_awaddr, s_wdata, s_wstrb     broadcast to all slaves
//   s_awvalid/s_wvalid/s_bready    per-slave (one bit per slave)
//   s_awready/s_wready/s_bvalid    per-slave (one bit per slave)
//   s_bresp                        per-slave, slave i in bits [2i+1:2i]
module axil_write_router #(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_W      = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   m_awaddr,
    input  logic                    m_awvalid,
    output logic                    m_awready,
    input  logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_wvalid,
    output logic                    m_wready,
    output logic [1:0]              m_bresp,
    output logic                    m_bvalid,
    input  logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   dec_addr,
    input  logic [SEL_W-1:0]        dec_sel,
    input  logic                    dec_hit,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic [N-1:0]            s_awvalid,
    input  logic [N-1:0]            s_awready,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic [N-1:0]            s_wvalid,
    input  logic [N-1:0]            s_wready,
    input  logic [2*N-1:0]          s_bresp,
    input  logic [N-1:0]            s_bvalid,
    output logic [N-1:0]            s_bready
);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_hit;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_aw_done;
    logic                    r_w_done;

    logic [N-1:0]            w_onehot;
    logic                    w_dec_valid;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;

    assign w_onehot    = {{(N-1){1'b0}}, 1'b1} << r_sel;
    // An index beyond the populated slave range is treated as a miss.
    assign w_dec_valid = dec_hit && (32'(dec_sel) < 32'(N));

    assign dec_addr = m_awaddr;
    assign s_awaddr = r_addr;
    assign s_wdata  = m_wdata;
    assign s_wstrb  = m_wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_hit     <= 1'b0;
            r_addr    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                IDLE: begin
                    if (m_awvalid) begin
                        r_addr    <= m_awaddr;
                        r_sel     <= dec_sel;
                        r_hit     <= w_dec_valid;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                FWD: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                RESP: begin
                    if (w_b_hs) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced to their idle values while rst is high, even though
    // the state register only returns to IDLE at the next edge.
    always_comb begin
        w_state_nxt = r_state;
        m_awready   = 1'b0;
        m_wready    = 1'b0;
        m_bvalid    = 1'b0;
        m_bresp     = 2'b00;
        s_awvalid   = '0;
        s_wvalid    = '0;
        s_bready    = '0;
        w_aw_hs     = 1'b0;
        w_w_hs      = 1'b0;
        w_b_hs      = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    m_awready = 1'b1;
                    if (m_awvalid) w_state_nxt = FWD;
                end
                FWD: begin
                    if (r_hit) begin
                        s_awvalid = r_aw_done ? '0 : w_onehot;
                        s_wvalid  = (m_wvalid && !r_w_done) ? w_onehot : '0;
                        m_wready  = s_wready[r_sel] && !r_w_done;
                        w_aw_hs   = !r_aw_done && s_awready[r_sel];
                        w_w_hs    = m_wvalid && s_wready[r_sel] && !r_w_done;
                        // A pair may finish via a registered flag or a
                        // handshake completing in this very cycle.
                        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                            w_state_nxt = RESP;
                    end else begin
                        m_wready = 1'b1;
                        w_w_hs   = m_wvalid;
                        if (m_wvalid) w_state_nxt = RESP;
                    end
                end
                RESP: begin
                    if (r_hit) begin
                        m_bvalid = s_bvalid[r_sel];
                        m_bresp  = s_bvalid[r_sel] ? s_bresp[2*r_sel +: 2] : 2'b00;
                        s_bready = m_bready ? w_onehot : '0;
                        w_b_hs   = s_bvalid[r_sel] && m_bready;
                    end else begin
                        m_bvalid = 1'b1;
                        m_bresp  = 2'b11;
                        w_b_hs   = m_bready;
                    end
                    if (w_b_hs) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_write_router.sv
// Directed testbench for axil_write_router (N=4). Expected responses and data
// are queued when a transaction is launched and consumed at the W and B
// handshakes.
module tb_axil_write_router;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   m_awaddr;
    logic            m_awvalid;
    logic            m_awready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wvalid;
    logic            m_wready;
    logic [1:0]      m_bresp;
    logic            m_bvalid;
    logic            m_bready;
    logic [AW-1:0]   dec_addr;
    logic [SW-1:0]   dec_sel;
    logic            dec_hit;
    logic [AW-1:0]   s_awaddr;
    logic [N-1:0]    s_awvalid;
    logic [N-1:0]    s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic [N-1:0]    s_wvalid;
    logic [N-1:0]    s_wready;
    logic [2*N-1:0]  s_bresp;
    logic [N-1:0]    s_bvalid;
    logic [N-1:0]    s_bready;

    always #5 clk = ~clk;

    axil_write_router #(
        .N          (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .dec_addr  (dec_addr),
        .dec_sel   (dec_sel),
        .dec_hit   (dec_hit),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready)
    );

    typedef struct {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one master write. aw_stall: cycles the selected slave holds
    // s_awready low; w_lead: cycles W is presented before AW; b_stall: cycles
    // the master holds m_bready low. Inputs change on the falling edge.
    task automatic run_txn(input logic [AW-1:0] addr, input logic [SW-1:0] sel,
                           input logic hit, input logic [DW-1:0] data,
                           input logic [1:0] resp, input int aw_stall,
                           input int w_lead, input int b_stall);
        exp_t         e;
        logic [N-1:0] oh;
        bit           awd;
        bit           wd;
        bit           done;
        int           cyc;
        e.resp = hit ? resp : 2'b11;
        e.data = data;
        sb.push_back(e);
        oh = hit ? (4'b0001 << sel) : 4'b0000;
        m_wdata = data;
        m_wstrb = 4'hF;
        if (w_lead > 0) begin
            m_wvalid = 1'b1;
            for (int i = 0; i < w_lead; i++) begin
                #1 chk("w_held_in_idle", m_wready, 1'b0);
                tick();
            end
        end
        m_awaddr  = addr;
        dec_sel   = sel;
        dec_hit   = hit;
        m_awvalid = 1'b1;
        m_wvalid  = 1'b1;
        #1;
        chk("dec_addr", dec_addr, addr);
        chk("awready_idle", m_awready, 1'b1);
        chk("wready_idle", m_wready, 1'b0);
        tick();
        m_awvalid = 1'b0;

        awd = 0; wd = 0; done = 0; cyc = 0;
        while (!done && cyc < 20) begin
            s_awready = (cyc >= aw_stall) ? 4'hF : 4'h0;
            s_wready  = 4'hF;
            #1;
            chk("s_awvalid", s_awvalid, awd ? 4'h0 : oh);
            chk("s_wvalid", s_wvalid, wd ? 4'h0 : oh);
            chk("m_wready_fwd", m_wready, hit ? !wd : 1'b1);
            chk("s_awaddr", s_awaddr, addr);
            chk("m_bvalid_fwd", m_bvalid, 1'b0);
            chk("m_bresp_fwd", m_bresp, 2'b00);
            if (hit && !wd) begin
                chk("s_wdata", s_wdata, sb[0].data);
                chk("s_wstrb", s_wstrb, 4'hF);
            end
            if (hit && s_awready[sel]) awd = 1;
            wd   = 1;
            done = wd && (awd || !hit);
            tick();
            cyc++;
        end
        if (!done) chk("fwd_timeout", 1'b0, 1'b1);
        chk("fwd_cycles", cyc, hit ? aw_stall + 1 : 1);

        s_bvalid = oh;
        s_bresp  = 8'(resp) << (2 * sel);
        done = 0; cyc = 0;
        while (!done && cyc < 20) begin
            m_bready = (cyc >= b_stall);
            #1;
            chk("m_bvalid", m_bvalid, 1'b1);
            chk("m_bresp", m_bresp, sb[0].resp);
            chk("s_bready", s_bready, m_bready ? oh : 4'h0);
            chk("m_awready_resp", m_awready, 1'b0);
            chk("m_wready_resp", m_wready, 1'b0);
            chk("s_awvalid_resp", s_awvalid, 4'h0);
            if (m_bready) begin
                void'(sb.pop_front());
                done = 1;
            end
            tick();
            cyc++;
        end
        if (!done) chk("resp_timeout", 1'b0, 1'b1);
        s_bvalid = '0;
        s_bresp  = '0;
        m_bready = 1'b0;
        m_wvalid = 1'b0;
        #1;
        chk("idle_after_b", m_awready, 1'b1);
        chk("bvalid_idle", m_bvalid, 1'b0);
        chk("bresp_idle", m_bresp, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0;
        m_wvalid = 1'b0; m_bready = 1'b0; dec_sel = '0; dec_hit = 1'b0;
        s_awready = '0; s_wready = '0; s_bresp = '0; s_bvalid = '0;
        tick();
        #1;
        chk("rst_awready", m_awready, 1'b0);
        chk("rst_wready", m_wready, 1'b0);
        chk("rst_bvalid", m_bvalid, 1'b0);
        chk("rst_bresp", m_bresp, 2'b00);
        chk("rst_awvalid", s_awvalid, 4'h0);
        chk("rst_wvalid", s_wvalid, 4'h0);
        chk("rst_bready", s_bready, 4'h0);
        chk("rst_awaddr", s_awaddr, 32'h0);
        tick();
        rst = 1'b0;
        #1 chk("post_rst_awready", m_awready, 1'b1);

        // Hit on slave 2, everything ready.
        run_txn(32'h0000_2010, 2'd2, 1'b1, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
        // Decode miss: W absorbed, DECERR.
        run_txn(32'hF000_0000, 2'd0, 1'b0, 32'h1234_5678, 2'b00, 0, 0, 0);
        // W three cycles ahead of AW, slave 1 stalls AW for 4 cycles.
        run_txn(32'h0000_1000, 2'd1, 1'b1, 32'hCAFE_F00D, 2'b00, 4, 3, 0);
        // Slave 0 SLVERR held while master stalls B for 5 cycles.
        run_txn(32'h0000_0040, 2'd0, 1'b1, 32'hA5A5_A5A5, 2'b10, 0, 0, 5);

        // Reset while slave 3 AW is pending.
        m_awaddr = 32'h0000_3000; dec_sel = 2'd3; dec_hit = 1'b1;
        m_awvalid = 1'b1; s_awready = '0;
        #1;
        tick();
        m_awvalid = 1'b0;
        #1 chk("pre_rst_awvalid", s_awvalid, 4'b1000);
        rst = 1'b1;
        #1;
        chk("midrst_awvalid", s_awvalid, 4'h0);
        chk("midrst_wvalid", s_wvalid, 4'h0);
        chk("midrst_awready", m_awready, 1'b0);
        chk("midrst_wready", m_wready, 1'b0);
        chk("midrst_bvalid", m_bvalid, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst_awready", m_awready, 1'b1);
        chk("after_rst_awvalid", s_awvalid, 4'h0);
        run_txn(32'h0000_3004, 2'd3, 1'b1, 32'h0BAD_F00D, 2'b01, 0, 0, 0);

        // Back-to-back: slave 0 then slave 1 with no master idle.
        run_txn(32'h0000_0100, 2'd0, 1'b1, 32'h1111_2222, 2'b00, 1, 0, 0);
        run_txn(32'h0000_1100, 2'd1, 1'b1, 32'h3333_4444, 2'b00, 0, 0, 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axil_write_router.md
Name: axil_write_router

Overview:
- Write-channel routing stage of the AXI-Lite interconnect. It sits directly downstream of the address-to-slave decoder and consumes the decoder's slave index and hit/miss result.
- Accepts one master write transaction (AW, W, B) at a time and forwards it to the slave the decoder selected.
- On a decode miss it absorbs the write data itself and returns DECERR.

Parameters:
- N, 4: number of slave ports (2..16).
- ADDR_WIDTH, 32: AXI-Lite address width.
- DATA_WIDTH, 32: data width (32 or 64).
- SEL_W, $clog2(N): width of the slave index.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  synchronous, active-high reset.
- m_awaddr  in  ADDR_WIDTH  master write address.
- m_awvalid  in  1  master AW valid.
- m_awready  out  1  master AW ready.
- m_wdata  in  DATA_WIDTH  master write data.
- m_wstrb  in  DATA_WIDTH/8  master write strobes.
- m_wvalid  in  1  master W valid.
- m_wready  out  1  master W ready.
- m_bresp  out  2  master write response.
- m_bvalid  out  1  master B valid.
- m_bready  in  1  master B ready.
- dec_addr  out  ADDR_WIDTH  address driven to the decoder; equals m_awaddr (combinational).
- dec_sel  in  SEL_W  decoder slave index.
- dec_hit  in  1  decoder hit; 0 means decode error.
- s_awaddr  out  ADDR_WIDTH  latched address, broadcast to all slaves.
- s_awvalid  out  N  per-slave AW valid.
- s_awready  in  N  per-slave AW ready.
- s_wdata  out  DATA_WIDTH  broadcast of m_wdata.
- s_wstrb  out  DATA_WIDTH/8  broadcast of m_wstrb.
- s_wvalid  out  N  per-slave W valid.
- s_wready  in  N  per-slave W ready.
- s_bresp  in  2N  per-slave responses; slave i occupies bits [2i+1:2i].
- s_bvalid  in  N  per-slave B valid.
- s_bready  out  N  per-slave B ready.

Behaviour:
- FSM states: IDLE, FWD, RESP. Internal registers: sel_q, hit_q, addr_q, aw_done, w_done.

- Reset: while rst=1, the state register goes to IDLE. All of these are 0: m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready, aw_done, w_done. m_bresp=0 and s_awaddr=0. Reset mid-transaction abandons it silently; there is no response to the master.

- IDLE:
  - m_awready=1 combinationally (0 while rst=1).
  - m_wready=0.
  - On m_awvalid&&m_awready: latch addr_q=m_awaddr, sel_q=dec_sel, hit_q=dec_hit; go to FWD next cycle.
  - dec_hit with dec_sel>=N is treated as a miss (hit_q=0).

- FWD, hit_q=1:
  - s_awvalid[sel_q]=1 from the first FWD cycle (one cycle after AW acceptance) until s_awready[sel_q]; then aw_done=1.
  - W is a combinational pass-through to slave sel_q: s_wvalid[sel_q]=m_wvalid&&!w_done, and m_wready=s_wready[sel_q]&&!w_done. Set w_done on the handshake.
  - AW and W complete independently, in either order or in the same cycle.
  - When both are done (registered flags, or the current-cycle handshake completing the pair), go to RESP next cycle.
  - All other slave valid bits stay 0.

- FWD, hit_q=0:
  - No slave valid is asserted.
  - m_wready=1 until one W beat is accepted; the data is discarded.
  - Then go to RESP.

- RESP, hit_q=1:
  - m_bvalid=s_bvalid[sel_q], m_bresp=s_bresp[sel_q], s_bready[sel_q]=m_bready.
  - On the handshake, go to IDLE and clear the flags.

- RESP, hit_q=0:
  - m_bvalid=1, m_bresp=2'b11 (DECERR).
  - On m_bready, go to IDLE.

- General rules:
  - One outstanding write only. AW is not accepted outside IDLE.
  - W arriving before AW is held off (m_wready=0 in IDLE), with no data loss.
  - Back-to-back transactions: the earliest next AW acceptance is the cycle after the B handshake.
  - s_awaddr=addr_q is stable throughout FWD. m_bresp=0 whenever m_bvalid=0.
  - Valids, once asserted, are never deasserted before their handshake.

- Latency on a hit with always-ready slaves and master:
  - AW accepted at cycle 0.
  - s_awvalid and the W transfer at cycle 1.
  - RESP entered at cycle 2.
  - m_bvalid in the same cycle the slave's bvalid appears.

Test Plan:
- Hit, slave 2, all ready: m_awaddr=0x2010, dec_sel=2, dec_hit=1, wdata=0xDEADBEEF, wstrb=0xF, slave bresp=OKAY. Expect: s_awvalid=4'b0100 at cycle 1; s_wdata=0xDEADBEEF to slave 2 only; m_bresp=2'b00; back in IDLE after the B handshake.
- Decode miss: m_awaddr=0xF000_0000, dec_hit=0. Expect: s_awvalid/s_wvalid stay 0 throughout; one W beat absorbed; m_bvalid=1 with m_bresp=2'b11; no slave B handshake.
- W before AW plus slave backpressure: m_wvalid asserted 3 cycles before m_awvalid; s_awready[1] low for 4 cycles, then high. Expect: m_wready=0 in IDLE; s_awvalid[1] held high through the stall; transfer completes with data intact.
- Master B backpressure: slave 0 returns SLVERR (2'b10) while m_bready is low for 5 cycles. Expect: m_bvalid and m_bresp=2'b10 stable; s_bready[0]=0 until m_bready=1; next AW accepted the cycle after the B handshake.
- Reset mid-FWD: assert rst for 1 cycle while s_awvalid[3]=1. Expect: all valids 0 and m_awready=0 during reset; m_awready=1 in the first cycle after reset; a new transaction to slave 3 completes normally.
- Back-to-back writes: slave 0, then slave 1, with no idle from the master. Expect: exactly one s_awvalid bit per transaction, correct ordering, and never two slave valid bits high at once.
